sim_pc_driver: RTL

SIM_PC_DRIVER -- requirements
Module: sim_pc_driver

---
 rtl/sim_intf_pkg.sv | 29 ++
 rtl/sim_miss_run_cnt.sv | 48 ++++
 rtl/sim_pc_driver.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/sim_intf_pkg.sv
// ============================================================================
// Module      : sim_intf_pkg
// Description : Shared types and defaults for the simulation PC driver
//               (PC type, driver state encoding, boot PC and step size).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sim_intf_pkg;

  typedef logic [63:0] pc_t;

  typedef enum logic [1:0] {
    DRV_IDLE = 2'd0,
    DRV_RUN  = 2'd1,
    DRV_DONE = 2'd2
  } drv_state_e;

  localparam pc_t         DEF_BOOT_PC = 64'h0000_0000_0000_1000;
  localparam int unsigned DEF_PC_STEP = 4;

  // Sequential PC advance; wraps silently modulo 2^64.
  function automatic pc_t pc_advance(input pc_t pc, input int unsigned step);
    return pc + pc_t'(step);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sim_miss_run_cnt.sv
// ============================================================================
// Module      : sim_miss_run_cnt
// Description : Saturating consecutive-miss counter. limit_hit flags that the
//               increment requested this cycle reaches LIMIT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sim_miss_run_cnt #(
  parameter int unsigned LIMIT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic limit_hit
);

  localparam int unsigned W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] c_limit = W'(LIMIT);
  localparam logic [W-1:0] c_last  = W'((LIMIT < 1) ? 0 : LIMIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear wins over increment; count saturates at LIMIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != c_limit)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit_hit = inc && (cnt_q >= c_last);

endmodule

`default_nettype wire

// File: rtl/sim_pc_driver.sv
// ============================================================================
// Module      : sim_pc_driver
// Description : Issues a stream of trial PCs to a checker, following checker
//               redirects on a miss, and stops after MAX_STEPS PCs or after
//               MAX_MISS_RUN consecutive misses (abort).
//               Optional statistics ports enabled by SIM_PC_DRIVER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sim_pc_driver
  import sim_intf_pkg::*;
#(
  parameter pc_t         BOOT_PC      = DEF_BOOT_PC,
  parameter int unsigned PC_STEP      = DEF_PC_STEP,
  parameter int unsigned MAX_STEPS    = 1024,
  parameter int unsigned MAX_MISS_RUN = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [63:0] pc_try,
  output logic        pc_valid,
  input  logic        miss,
  input  logic [63:0] pc_factual,
  output logic        done,
  output logic        abort
`ifdef SIM_PC_DRIVER_STATS_EN
  ,
  output logic [31:0] miss_total,
  output logic [63:0] redirect_last_pc
`endif
);

  localparam logic [1:0] ST_IDLE = DRV_IDLE;
  localparam logic [1:0] ST_RUN  = DRV_RUN;
  localparam logic [1:0] ST_DONE = DRV_DONE;

  localparam int unsigned SW = $clog2(MAX_STEPS + 1);
  localparam logic [SW-1:0] c_max_steps = SW'(MAX_STEPS);
  localparam logic [SW-1:0] c_step_one  = SW'(1);

  logic [1:0]    state_q, state_d;
  pc_t           pc_q, pc_d;
  logic [SW-1:0] step_q, step_d;
  logic          done_q, done_d;
  logic          abort_q, abort_d;
  logic          armed_q, armed_d;   // start=0 seen since entering DONE
  logic          fresh_run;
  logic          run_miss;
  logic          cnt_clr;
  logic          miss_limit_hit;

  // Miss only counts while a PC is actually being presented.
  assign run_miss = (state_q == ST_RUN) && miss;

  sim_miss_run_cnt #(
    .LIMIT (MAX_MISS_RUN)
  ) u_miss_run_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cnt_clr),
    .inc       (run_miss),
    .limit_hit (miss_limit_hit)
  );

  // Next-state logic: abort outranks step limit; finishing freezes pc_try.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    step_d    = step_q;
    done_d    = done_q;
    abort_d   = abort_q;
    armed_d   = armed_q;
    fresh_run = 1'b0;
    cnt_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) fresh_run = 1'b1;
      end
      ST_RUN: begin
        cnt_clr = !miss;
        if (miss_limit_hit) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          abort_d = 1'b1;
          armed_d = 1'b0;
        end else if (step_q == c_max_steps) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          armed_d = 1'b0;
        end else begin
          step_d = step_q + c_step_one;
          pc_d   = miss ? pc_factual : pc_advance(pc_q, PC_STEP);
        end
      end
      ST_DONE: begin
        if (!start) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          fresh_run = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (fresh_run) begin
      state_d = ST_RUN;
      pc_d    = BOOT_PC;
      step_d  = c_step_one;
      done_d  = 1'b0;
      abort_d = 1'b0;
      armed_d = 1'b0;
      cnt_clr = 1'b1;
    end
  end

  // Driver state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      step_q  <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      step_q  <= step_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      armed_q <= armed_d;
    end
  end

  assign pc_try   = pc_q;
  assign pc_valid = (state_q == ST_RUN);
  assign done     = done_q;
  assign abort    = abort_q;

`ifdef SIM_PC_DRIVER_STATS_EN
  logic [31:0] miss_total_q, miss_total_d;
  pc_t         redirect_last_q, redirect_last_d;

  // Statistics: saturating miss count and PC of the latest miss.
  always_comb begin
    miss_total_d    = miss_total_q;
    redirect_last_d = redirect_last_q;
    if (fresh_run) begin
      miss_total_d    = '0;
      redirect_last_d = '0;
    end else if (run_miss) begin
      if (miss_total_q != 32'hFFFF_FFFF) miss_total_d = miss_total_q + 32'd1;
      redirect_last_d = pc_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_total_q    <= '0;
      redirect_last_q <= '0;
    end else begin
      miss_total_q    <= miss_total_d;
      redirect_last_q <= redirect_last_d;
    end
  end

  assign miss_total       = miss_total_q;
  assign redirect_last_pc = redirect_last_q;
`endif

endmodule

`default_nettype wire
